// File: rtl/decode_regfile_sb.sv
// decode_regfile_sb: decode-stage register file with a busy-bit scoreboard.
//   Register contents have no reset. After reset a sweep writes zero to one
//   register per cycle, and `ready` rises once every register has been zeroed.
//   Reads are combinational. An optional bypass forwards same-cycle write data
//   to the read ports and masks the matching busy bits.
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   ready                 init sweep done; reads, writes and scoreboard live
//   we/wa/wd              per-port write enable, address and data (packed)
//   rs/rd                 per-port read address and read data (packed)
//   rs_busy               scoreboard busy bit for each read address
//   sb_set/sb_set_ptr     mark a destination register busy
//   sb_flush              clear every busy bit
module decode_regfile_sb #(
  parameter int REGS_PTR_W = 5,
  parameter int REGS_NUM   = 32,
  parameter int REG_SIZE   = 32,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             ready,
  input  logic [WR_PORTS-1:0]              we,
  input  logic [WR_PORTS*REGS_PTR_W-1:0]   wa,
  input  logic [WR_PORTS*REG_SIZE-1:0]     wd,
  input  logic [RD_PORTS*REGS_PTR_W-1:0]   rs,
  output logic [RD_PORTS*REG_SIZE-1:0]     rd,
  output logic [RD_PORTS-1:0]              rs_busy,
  input  logic                             sb_set,
  input  logic [REGS_PTR_W-1:0]            sb_set_ptr,
  input  logic                             sb_flush
);

  localparam logic [REGS_PTR_W:0]   NUM_C = (REGS_PTR_W+1)'(REGS_NUM);
  localparam logic [REGS_PTR_W-1:0] LAST  = REGS_PTR_W'(REGS_NUM - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state;
  logic [REGS_PTR_W-1:0]   cnt;
  logic [REG_SIZE-1:0]     regs [0:REGS_NUM-1];
  logic [REGS_NUM-1:0]     busy;
  logic [REGS_NUM-1:0]     busy_nxt;
  logic [WR_PORTS-1:0]     wr_ok;

  logic [REGS_PTR_W-1:0]   wa_a [WR_PORTS];
  logic [REG_SIZE-1:0]     wd_a [WR_PORTS];
  logic [REGS_PTR_W-1:0]   rs_a [RD_PORTS];

  for (genvar g = 0; g < WR_PORTS; g++) begin : g_wr_unpack
    assign wa_a[g] = wa[g*REGS_PTR_W +: REGS_PTR_W];
    assign wd_a[g] = wd[g*REG_SIZE +: REG_SIZE];
  end

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd_unpack
    assign rs_a[g] = rs[g*REGS_PTR_W +: REGS_PTR_W];
  end

  // An address that names a real, writable register (excludes out-of-range
  // addresses and the hardwired zero register).
  function automatic logic addr_ok(input logic [REGS_PTR_W-1:0] a);
    return ({1'b0, a} < NUM_C) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    for (int i = 0; i < WR_PORTS; i++)
      wr_ok[i] = (state == RUN) && we[i] && addr_ok(wa_a[i]);
  end

  // Scoreboard next state: flush first, then write clears, then the set, so a
  // new producer always wins over both.
  always_comb begin
    busy_nxt = busy;
    if (sb_flush)
      busy_nxt = '0;
    for (int i = 0; i < WR_PORTS; i++)
      if (wr_ok[i])
        busy_nxt[wa_a[i]] = 1'b0;
    if (sb_set && addr_ok(sb_set_ptr))
      busy_nxt[sb_set_ptr] = 1'b1;
  end

  // Control: sweep FSM, ready flag and busy bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
      busy  <= '0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN:     busy  <= busy_nxt;
        default: state <= INIT;
      endcase
    end
  end

  // Register array: no reset; the sweep zeroes it. Later ports are assigned
  // last, so the highest-index port wins on an address collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        regs[cnt] <= '0;
      end else begin
        for (int i = 0; i < WR_PORTS; i++)
          if (wr_ok[i])
            regs[wa_a[i]] <= wd_a[i];
      end
    end
  end

  always_comb begin
    rd      = '0;
    rs_busy = '0;
    for (int j = 0; j < RD_PORTS; j++) begin
      if ((state == RUN) && addr_ok(rs_a[j])) begin
        rd[j*REG_SIZE +: REG_SIZE] = regs[rs_a[j]];
        rs_busy[j]                 = busy[rs_a[j]];
        if (BYPASS != 0) begin
          for (int i = 0; i < WR_PORTS; i++) begin
            if (wr_ok[i] && (wa_a[i] == rs_a[j])) begin
              rd[j*REG_SIZE +: REG_SIZE] = wd_a[i];
              rs_busy[j]                 = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_regfile_sb.sv
// Testbench for decode_regfile_sb (default parameters): random and directed
// stimulus, a reference model of the register file and scoreboard, and a
// monitor that pops the expected outputs from a queue and compares them.
module tb_decode_regfile_sb;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  rs;
  logic [63:0] rd;
  logic [1:0]  rs_busy;
  logic        sb_set;
  logic [4:0]  sb_set_ptr;
  logic        sb_flush;

  always #5 clk = ~clk;

  decode_regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .we(we), .wa(wa), .wd(wd), .rs(rs), .rd(rd), .rs_busy(rs_busy),
    .sb_set(sb_set), .sb_set_ptr(sb_set_ptr), .sb_flush(sb_flush)
  );

  typedef struct {
    logic [31:0] rd0, rd1;
    logic        b0, b1, rdy;
    int          cyc;
  } exp_t;

  exp_t        q [$];
  logic [31:0] mem   [N];
  bit          mbusy [N];
  int          mcnt = 0;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  // Reference: a register is visible only after the sweep; reg 0 is always 0;
  // the last accepted writer in port order is forwarded and un-busies the read.
  function automatic exp_t predict();
    exp_t        e;
    logic [31:0] r [2];
    logic        b [2];
    int          a, w;
    for (int j = 0; j < 2; j++) begin
      a = int'(rs[j*5 +: 5]);
      r[j] = 32'h0;
      b[j] = 1'b0;
      if (mcnt >= N && a != 0) begin
        r[j] = mem[a];
        b[j] = mbusy[a];
        for (int i = 0; i < 2; i++) begin
          w = int'(wa[i*5 +: 5]);
          if (we[i] && w == a) begin
            r[j] = wd[i*32 +: 32];
            b[j] = 1'b0;
          end
        end
      end
    end
    e.rd0 = r[0]; e.rd1 = r[1]; e.b0 = b[0]; e.b1 = b[1];
    e.rdy = (mcnt >= N);
    e.cyc = cyc;
    return e;
  endfunction

  task automatic update_model();
    int w;
    if (!rst_n) begin
      mcnt = 0;
      for (int k = 0; k < N; k++) mbusy[k] = 0;
    end else if (mcnt < N) begin
      mcnt++;
      if (mcnt == N)
        for (int k = 0; k < N; k++) mem[k] = 32'h0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        w = int'(wa[i*5 +: 5]);
        if (we[i] && w != 0) mem[w] = wd[i*32 +: 32];
      end
      if (sb_flush)
        for (int k = 0; k < N; k++) mbusy[k] = 0;
      for (int i = 0; i < 2; i++) begin
        w = int'(wa[i*5 +: 5]);
        if (we[i] && w != 0) mbusy[w] = 0;
      end
      if (sb_set && sb_set_ptr != 0) mbusy[sb_set_ptr] = 1;
    end
  endtask

  task automatic step(input bit push);
    if (push) q.push_back(predict());
    @(posedge clk);
    update_model();
    cyc++;
    #1;
  endtask

  task automatic idle();
    we = '0; sb_set = 1'b0; sb_flush = 1'b0; sb_set_ptr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    we[p] = 1'b1;
    wa[p*5 +: 5] = a[4:0];
    wd[p*32 +: 32] = d;
  endtask

  task automatic rdp(input int a0, input int a1);
    rs[4:0] = a0[4:0];
    rs[9:5] = a1[4:0];
  endtask

  task automatic randomize_inputs(input int amax);
    we = 2'($urandom);
    wa = {5'($urandom_range(amax)), 5'($urandom_range(amax))};
    wd = {$urandom, $urandom};
    rs = {5'($urandom_range(amax)), 5'($urandom_range(amax))};
    sb_set = ($urandom_range(2) != 0);
    sb_set_ptr = 5'($urandom_range(amax));
    sb_flush = ($urandom_range(15) == 0);
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, got, exp);
    else
      passed++;
  endtask

  // Monitor: outputs are combinational, so one expectation per checked cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ready", e.cyc, 32'(ready), 32'(e.rdy));
      chk("rd0", e.cyc, rd[31:0], e.rd0);
      chk("rd1", e.cyc, rd[63:32], e.rd1);
      chk("busy0", e.cyc, 32'(rs_busy[0]), 32'(e.b0));
      chk("busy1", e.cyc, 32'(rs_busy[1]), 32'(e.b1));
    end
  end

  initial begin
    rst_n = 1'b0; idle(); wa = '0; wd = '0; rs = '0;
    step(0);
    step(1);
    rst_n = 1'b1;

    // Sweep with noisy inputs that must all be ignored.
    for (int k = 0; k < N + 2; k++) begin
      randomize_inputs(31);
      step(1);
    end

    // Every register reads zero after the sweep.
    idle();
    for (int k = 0; k < N; k += 2) begin rdp(k, k + 1); step(1); end

    // Write then read, with same-cycle bypass.
    idle(); wr(0, 5, 32'hDEADBEEF); rdp(5, 5); step(1);
    idle(); step(1);
    // Collision on reg7, write to reg0.
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); rdp(7, 0); step(1);
    idle(); wr(0, 0, 32'hFFFF); rdp(0, 7); step(1);
    idle(); rdp(0, 7); step(1);
    // Scoreboard set, bypass clear, set+write same register.
    sb_set = 1; sb_set_ptr = 9; rdp(9, 9); step(1);
    idle(); step(1);
    wr(1, 9, 32'h99); step(1);
    idle(); step(1);
    sb_set = 1; sb_set_ptr = 9; wr(0, 9, 32'h98); step(1);
    idle(); step(1);
    // Flush together with a set.
    sb_set = 1; sb_set_ptr = 3; step(1);
    sb_set_ptr = 4; step(1);
    sb_set_ptr = 6; rdp(3, 4); step(1);
    sb_set_ptr = 4; sb_flush = 1; rdp(3, 6); step(1);
    idle(); rdp(3, 4); step(1);
    rdp(6, 4); step(1);
    sb_set = 1; sb_set_ptr = 0; rdp(0, 0); step(1);
    idle(); step(1);

    // Random traffic on a small address window to force collisions.
    for (int k = 0; k < 400; k++) begin
      randomize_inputs(11);
      step(1);
    end

    // Reset in RUN with busy bits set, then a full sweep.
    idle();
    for (int k = 1; k < 8; k++) begin sb_set = 1; sb_set_ptr = 5'(k); wr(0, k, 32'(k * 3 + 1)); step(1); end
    idle(); rdp(1, 2); step(1);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1;
    for (int k = 0; k < N + 2; k++) begin rdp(k % 8, (k + 1) % 8); step(1); end
    for (int k = 0; k < 20; k++) begin randomize_inputs(31); step(1); end

    idle();
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
